// File: rtl/usb_reset_ctrl_if.sv
// Pin-side inputs and core-side outputs of the USB reset / bus-state controller.
interface usb_reset_ctrl_if;
  logic       usb_p_in;
  logic       usb_n_in;
  logic       tx_en;
  logic       clear_count;
  logic       core_reset;
  logic       bus_reset;
  logic       bus_reset_pulse;
  logic       suspend;
  logic       resume_pulse;
  logic [1:0] line_state;
  logic [7:0] reset_count;

  modport master (
    output usb_p_in,
    output usb_n_in,
    output tx_en,
    output clear_count,
    input  core_reset,
    input  bus_reset,
    input  bus_reset_pulse,
    input  suspend,
    input  resume_pulse,
    input  line_state,
    input  reset_count
  );

  modport slave (
    input  usb_p_in,
    input  usb_n_in,
    input  tx_en,
    input  clear_count,
    output core_reset,
    output bus_reset,
    output bus_reset_pulse,
    output suspend,
    output resume_pulse,
    output line_state,
    output reset_count
  );
endinterface

// File: rtl/usb_reset_ctrl.sv
// Core reset generation (external reset, power-on hold, bus-reset stretch) and
// USB bus reset / suspend / resume detection on the raw D+/D- lines.
module usb_reset_ctrl #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned POR_CYCLES     = 32,
  parameter int unsigned FILTER_LEN     = 3,
  parameter int unsigned SE0_CYCLES     = 160000,
  parameter int unsigned SUSPEND_CYCLES = 144000,
  parameter int unsigned STRETCH_CYCLES = 16
) (
  input  logic            clk_48mhz,
  input  logic            reset,
  usb_reset_ctrl_if.slave bus
);

  localparam int unsigned POR_W  = $clog2(POR_CYCLES + 1);
  localparam int unsigned FILT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned STR_W  = (STRETCH_CYCLES > 0) ? $clog2(STRETCH_CYCLES + 1) : 1;

  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_SE0 = 2'b00;

  localparam logic [POR_W-1:0]  POR_MAX   = POR_W'(POR_CYCLES);
  localparam logic [FILT_W-1:0] FILT_MAX  = FILT_W'(FILTER_LEN);
  localparam logic [CNT_W-1:0]  SE0_MAX   = CNT_W'(SE0_CYCLES);
  localparam logic [CNT_W-1:0]  SE0_LAST  = CNT_W'(SE0_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SUSP_MAX  = CNT_W'(SUSPEND_CYCLES);
  localparam logic [CNT_W-1:0]  SUSP_LAST = CNT_W'(SUSPEND_CYCLES - 1);
  localparam logic [STR_W-1:0]  STR_LOAD  = STR_W'(STRETCH_CYCLES);

  // input path
  logic [1:0]        sync1_q, sync1_d;
  logic [1:0]        sync2_q, sync2_d;
  logic [1:0]        s_prev_q, s_prev_d;
  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic [FILT_W-1:0] filt_next;
  logic [1:0]        line_state_q, line_state_d;

  // reset generation
  logic [POR_W-1:0]  por_cnt_q, por_cnt_d;
  logic              por_active;
  logic [STR_W-1:0]  stretch_cnt_q, stretch_cnt_d;
  logic              stretch_run_q, stretch_run_d;

  // bus reset detection
  logic [CNT_W-1:0]  se0_cnt_q, se0_cnt_d;
  logic              se0_cond;
  logic              se0_hit;
  logic              bus_reset_q, bus_reset_d;
  logic              bus_reset_pulse_q, bus_reset_pulse_d;
  logic [7:0]        reset_count_q, reset_count_d;

  // suspend / resume detection
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic              idle_cond;
  logic              idle_hit;
  logic              suspend_q, suspend_d;
  logic              resume_pulse_q, resume_pulse_d;

  // Two-flop synchroniser, then a filter that adopts a new line state only
  // after it has been stable for FILTER_LEN consecutive cycles.
  always_comb begin
    sync1_d      = {bus.usb_p_in, bus.usb_n_in};
    sync2_d      = sync1_q;
    s_prev_d     = sync2_q;
    line_state_d = line_state_q;
    filt_cnt_d   = '0;
    filt_next    = FILT_W'(1);
    if (sync2_q != line_state_q) begin
      if (sync2_q == s_prev_q) begin
        filt_next = filt_cnt_q + FILT_W'(1);
      end
      if (filt_next == FILT_MAX) begin
        line_state_d = sync2_q;
      end else begin
        filt_cnt_d = filt_next;
      end
    end
  end

  // Power-on hold and post-bus-reset stretch.
  always_comb begin
    por_active    = (por_cnt_q != POR_MAX);
    por_cnt_d     = por_active ? por_cnt_q + POR_W'(1) : por_cnt_q;
    stretch_cnt_d = stretch_cnt_q;
    stretch_run_d = stretch_run_q;
    if (bus_reset_q && !bus_reset_d) begin
      stretch_run_d = 1'b1;
      stretch_cnt_d = STR_LOAD;
    end else if (stretch_run_q) begin
      if (stretch_cnt_q == '0) begin
        stretch_run_d = 1'b0;
      end else begin
        stretch_cnt_d = stretch_cnt_q - STR_W'(1);
      end
    end
  end

  // Sustained SE0 while the device is not transmitting qualifies a bus reset.
  always_comb begin
    se0_cond          = (line_state_q == LS_SE0) && !bus.tx_en;
    se0_hit           = se0_cond && (se0_cnt_q == SE0_LAST);
    se0_cnt_d         = '0;
    if (se0_cond) begin
      se0_cnt_d = (se0_cnt_q == SE0_MAX) ? se0_cnt_q : se0_cnt_q + CNT_W'(1);
    end
    bus_reset_d       = se0_cond && (bus_reset_q || se0_hit);
    bus_reset_pulse_d = se0_hit;
  end

  // Count is bumped the cycle after the strobe, so a clear on the strobe cycle wins.
  always_comb begin
    reset_count_d = reset_count_q;
    if (bus.clear_count) begin
      reset_count_d = '0;
    end else if (bus_reset_pulse_q && (reset_count_q != 8'hFF)) begin
      reset_count_d = reset_count_q + 8'd1;
    end
  end

  // Sustained idle J qualifies suspend; any other bus activity ends it.
  always_comb begin
    idle_cond      = (line_state_q == LS_J) && !bus.tx_en;
    idle_hit       = idle_cond && (idle_cnt_q == SUSP_LAST);
    idle_cnt_d     = '0;
    if (idle_cond) begin
      idle_cnt_d = (idle_cnt_q == SUSP_MAX) ? idle_cnt_q : idle_cnt_q + CNT_W'(1);
    end
    suspend_d      = suspend_q;
    resume_pulse_d = 1'b0;
    if (suspend_q) begin
      if (bus.tx_en) begin
        suspend_d = 1'b0;
      end else if (line_state_q != LS_J) begin
        suspend_d      = 1'b0;
        resume_pulse_d = 1'b1;
      end
    end else if (idle_hit) begin
      suspend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      sync1_q           <= LS_J;
      sync2_q           <= LS_J;
      s_prev_q          <= LS_J;
      filt_cnt_q        <= '0;
      line_state_q      <= LS_J;
      por_cnt_q         <= '0;
      stretch_cnt_q     <= '0;
      stretch_run_q     <= 1'b0;
      se0_cnt_q         <= '0;
      bus_reset_q       <= 1'b0;
      bus_reset_pulse_q <= 1'b0;
      reset_count_q     <= '0;
      idle_cnt_q        <= '0;
      suspend_q         <= 1'b0;
      resume_pulse_q    <= 1'b0;
    end else begin
      sync1_q           <= sync1_d;
      sync2_q           <= sync2_d;
      s_prev_q          <= s_prev_d;
      filt_cnt_q        <= filt_cnt_d;
      line_state_q      <= line_state_d;
      por_cnt_q         <= por_cnt_d;
      stretch_cnt_q     <= stretch_cnt_d;
      stretch_run_q     <= stretch_run_d;
      se0_cnt_q         <= se0_cnt_d;
      bus_reset_q       <= bus_reset_d;
      bus_reset_pulse_q <= bus_reset_pulse_d;
      reset_count_q     <= reset_count_d;
      idle_cnt_q        <= idle_cnt_d;
      suspend_q         <= suspend_d;
      resume_pulse_q    <= resume_pulse_d;
    end
  end

  // core_reset is the only output that is not a direct flop.
  assign bus.core_reset      = reset | por_active | bus_reset_q | stretch_run_q;
  assign bus.bus_reset       = bus_reset_q;
  assign bus.bus_reset_pulse = bus_reset_pulse_q;
  assign bus.suspend         = suspend_q;
  assign bus.resume_pulse    = resume_pulse_q;
  assign bus.line_state      = line_state_q;
  assign bus.reset_count     = reset_count_q;

endmodule
